bypass_rf_free_sequencer: RTL and testbench

In-order write-name release controller for the bypass register file. Pipeline stages finish with write names out of order, but the register file only accepts a free for the oldest outstanding name. This block records out-of-order release requests, drives the register file's write-free port (`W_F`/`WFE`) strictly in allocation order, and mirrors occupancy so allocation can be throttled. It sits between the pipeline's writeback/commit stages and the register file's free port.

---
 rtl/bypass_rf_free_sequencer.sv | 110 +++++++++++
 tb/tb_bypass_rf_free_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bypass_rf_free_sequencer.sv
// In-order write-name release controller for the bypass register file.
// Records out-of-order release requests and frees names strictly oldest-first,
// while tracking occupancy so the allocator can be throttled.
module bypass_rf_free_sequencer #(
  parameter int unsigned name_width = 2,
  parameter int unsigned numNames   = 2**name_width
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ALLOC_FIRE,
  input  logic [name_width-1:0] ALLOC_NAME,
  input  logic                  FREE_REQ,
  input  logic [name_width-1:0] FREE_NAME,
  input  logic                  F_READY,
  output logic [name_width-1:0] W_F,
  output logic                  WFE,
  output logic                  ALLOC_ROOM,
  output logic [name_width:0]   OUTSTANDING,
  output logic                  IDLE,
  output logic                  ERR
);

  localparam int unsigned CntW = name_width + 1;
  localparam logic [CntW-1:0] NumNamesC = CntW'(numNames);

  logic [numNames-1:0]   alloc_q, alloc_d;
  logic [numNames-1:0]   pend_q,  pend_d;
  logic [name_width-1:0] head_q,  head_d;
  logic [name_width-1:0] tail_q,  tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  err_q,   err_d;

  logic wfe_c;
  logic retire_c;
  logic alloc_ok_c;
  logic free_ok_c;

  // Event qualification, all from registered state and this cycle's requests
  always_comb begin
    wfe_c      = alloc_q[head_q] && pend_q[head_q];
    retire_c   = wfe_c && F_READY;
    alloc_ok_c = ALLOC_FIRE && (ALLOC_NAME == tail_q) && !alloc_q[tail_q]
                 && (count_q < NumNamesC);
    free_ok_c  = FREE_REQ && alloc_q[FREE_NAME] && !pend_q[FREE_NAME];
  end

  // Next-state: retire at head, allocate at tail, mark releases pending
  always_comb begin
    alloc_d = alloc_q;
    pend_d  = pend_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (retire_c) begin
      alloc_d[head_q] = 1'b0;
      pend_d[head_q]  = 1'b0;
      head_d          = head_q + name_width'(1);
    end

    if (alloc_ok_c) begin
      alloc_d[tail_q] = 1'b1;
      tail_d          = tail_q + name_width'(1);
    end else if (ALLOC_FIRE) begin
      err_d = 1'b1;
    end

    // A release of the retiring head is already rejected by pend_q[head_q]
    if (free_ok_c) begin
      pend_d[FREE_NAME] = 1'b1;
    end else if (FREE_REQ) begin
      err_d = 1'b1;
    end

    if (alloc_ok_c && !retire_c) begin
      count_d = count_q + CntW'(1);
    end else if (!alloc_ok_c && retire_c) begin
      count_d = count_q - CntW'(1);
    end
  end

  // State register; reset discards all outstanding and pending names
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      alloc_q <= '0;
      pend_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs are pure functions of registered state
  assign W_F         = head_q;
  assign WFE         = wfe_c;
  assign ALLOC_ROOM  = count_q < NumNamesC;
  assign OUTSTANDING = count_q;
  assign IDLE        = (count_q == '0);
  assign ERR         = err_q;

endmodule

// File: tb/tb_bypass_rf_free_sequencer.sv
// Bench for bypass_rf_free_sequencer: directed vector table plus randomized
// traffic compared against an allocation-order queue model.
module tb_bypass_rf_free_sequencer;

  localparam int NW = 2;
  localparam int NN = 4;

  logic          CLK;
  logic          RST_N;
  logic          ALLOC_FIRE;
  logic [NW-1:0] ALLOC_NAME;
  logic          FREE_REQ;
  logic [NW-1:0] FREE_NAME;
  logic          F_READY;
  logic [NW-1:0] W_F;
  logic          WFE;
  logic          ALLOC_ROOM;
  logic [NW:0]   OUTSTANDING;
  logic          IDLE;
  logic          ERR;

  bypass_rf_free_sequencer #(.name_width(NW), .numNames(NN)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ALLOC_FIRE(ALLOC_FIRE), .ALLOC_NAME(ALLOC_NAME),
    .FREE_REQ(FREE_REQ), .FREE_NAME(FREE_NAME), .F_READY(F_READY),
    .W_F(W_F), .WFE(WFE), .ALLOC_ROOM(ALLOC_ROOM),
    .OUTSTANDING(OUTSTANDING), .IDLE(IDLE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit pre_rst;
    bit af; int an; bit fq; int fn; bit fr;
    int wf; bit wfe; bit room; int outs; bit idle; bit err;
  } vec_t;

  vec_t tbl[$];

  // Reference model: names outstanding in allocation order, plus released set
  int m_head;
  int mq[$];
  bit m_rel[NN];
  bit m_err;

  function automatic vec_t mk(bit pr, bit af, int an, bit fq, int fn, bit fr,
                              int wf, bit wfe, bit room, int outs, bit idle, bit err);
    vec_t v;
    v.pre_rst = pr; v.af = af; v.an = an; v.fq = fq; v.fn = fn; v.fr = fr;
    v.wf = wf; v.wfe = wfe; v.room = room; v.outs = outs; v.idle = idle; v.err = err;
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic chk_all(string tag, int wf, bit wfe, bit room, int outs, bit idle, bit err);
    chk({tag, " W_F"}, int'(W_F), wf);
    chk({tag, " WFE"}, int'(WFE), int'(wfe));
    chk({tag, " ALLOC_ROOM"}, int'(ALLOC_ROOM), int'(room));
    chk({tag, " OUTSTANDING"}, int'(OUTSTANDING), outs);
    chk({tag, " IDLE"}, int'(IDLE), int'(idle));
    chk({tag, " ERR"}, int'(ERR), int'(err));
  endtask

  function automatic void model_reset();
    m_head = 0;
    mq.delete();
    for (int i = 0; i < NN; i++) m_rel[i] = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic bit model_wfe();
    return (mq.size() > 0) && m_rel[mq[0]];
  endfunction

  function automatic void model_step(bit af, int an, bit fq, int fn, bit fr);
    bit retire, acc_a, acc_r, found;
    int tail;
    retire = model_wfe() && fr;
    tail   = (m_head + mq.size()) % NN;
    acc_a  = af && (an == tail) && (mq.size() < NN);
    found  = 1'b0;
    foreach (mq[i]) if (mq[i] == fn) found = 1'b1;
    acc_r  = fq && found && !m_rel[fn];
    if ((af && !acc_a) || (fq && !acc_r)) m_err = 1'b1;
    if (retire) begin
      m_rel[mq[0]] = 1'b0;
      void'(mq.pop_front());
      m_head = (m_head + 1) % NN;
    end
    if (acc_a) mq.push_back(an);
    if (acc_r) m_rel[fn] = 1'b1;
  endfunction

  // Asynchronous reset asserted between edges; outputs checked before any edge
  task automatic do_reset();
    @(negedge CLK);
    ALLOC_FIRE = 1'b0; FREE_REQ = 1'b0; F_READY = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_all("async_reset", 0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic drive_cycle(bit af, int an, bit fq, int fn, bit fr);
    @(negedge CLK);
    ALLOC_FIRE = af; ALLOC_NAME = NW'(an);
    FREE_REQ = fq;   FREE_NAME = NW'(fn);
    F_READY = fr;
    model_step(af, an, fq, fn, fr);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST_N = 1'b0; ALLOC_FIRE = 1'b0; ALLOC_NAME = '0;
    FREE_REQ = 1'b0; FREE_NAME = '0; F_READY = 1'b0;
    model_reset();
    #12;
    chk_all("reset", 0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Allocate 0..2, release out of order, drain in order
    tbl.push_back(mk(0, 1,0, 0,0, 1,  0,0,1,1,0,0));
    tbl.push_back(mk(0, 1,1, 0,0, 1,  0,0,1,2,0,0));
    tbl.push_back(mk(0, 1,2, 0,0, 1,  0,0,1,3,0,0));
    tbl.push_back(mk(0, 0,0, 1,2, 1,  0,0,1,3,0,0));
    tbl.push_back(mk(0, 0,0, 1,1, 1,  0,0,1,3,0,0));
    tbl.push_back(mk(0, 0,0, 1,0, 1,  0,1,1,3,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  1,1,1,2,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  2,1,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  3,0,1,0,1,0));
    // Backpressure on name 3
    tbl.push_back(mk(0, 1,3, 0,0, 0,  3,0,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 1,3, 0,  3,1,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,  3,1,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 0,  3,1,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  0,0,1,0,1,0));
    // Fill, overflow, wrap
    tbl.push_back(mk(0, 1,0, 0,0, 1,  0,0,1,1,0,0));
    tbl.push_back(mk(0, 1,1, 0,0, 1,  0,0,1,2,0,0));
    tbl.push_back(mk(0, 1,2, 0,0, 1,  0,0,1,3,0,0));
    tbl.push_back(mk(0, 1,3, 0,0, 1,  0,0,0,4,0,0));
    tbl.push_back(mk(0, 1,0, 0,0, 1,  0,0,0,4,0,1));
    tbl.push_back(mk(0, 0,0, 1,0, 1,  0,1,0,4,0,1));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  1,0,1,3,0,1));
    tbl.push_back(mk(0, 1,0, 0,0, 1,  1,0,0,4,0,1));
    tbl.push_back(mk(0, 0,0, 1,1, 0,  1,1,0,4,0,1));
    tbl.push_back(mk(0, 0,0, 1,2, 0,  1,1,0,4,0,1));
    // Alloc alongside retire while full is still rejected
    tbl.push_back(mk(0, 1,1, 0,0, 1,  2,1,1,3,0,1));
    tbl.push_back(mk(0, 0,0, 1,3, 0,  2,1,1,3,0,1));
    // Release of unallocated name, ERR sticky
    tbl.push_back(mk(1, 0,0, 1,3, 1,  0,0,1,0,1,1));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  0,0,1,0,1,1));
    tbl.push_back(mk(0, 0,0, 0,0, 1,  0,0,1,0,1,1));
    // Double release
    tbl.push_back(mk(1, 1,0, 0,0, 1,  0,0,1,1,0,0));
    tbl.push_back(mk(0, 1,1, 0,0, 1,  0,0,1,2,0,0));
    tbl.push_back(mk(0, 0,0, 1,1, 1,  0,0,1,2,0,0));
    tbl.push_back(mk(0, 0,0, 1,1, 1,  0,0,1,2,0,1));
    // Alloc with wrong name
    tbl.push_back(mk(1, 1,2, 0,0, 1,  0,0,1,0,1,1));
    // Release of head in the cycle head retires
    tbl.push_back(mk(1, 1,0, 0,0, 1,  0,0,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 1,0, 0,  0,1,1,1,0,0));
    tbl.push_back(mk(0, 0,0, 1,0, 1,  1,0,1,0,1,1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].pre_rst) do_reset();
      drive_cycle(tbl[i].af, tbl[i].an, tbl[i].fq, tbl[i].fn, tbl[i].fr);
      chk_all($sformatf("vec%0d", i), tbl[i].wf, tbl[i].wfe, tbl[i].room,
              tbl[i].outs, tbl[i].idle, tbl[i].err);
    end

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit af, fq, fr;
      int an, fn;
      if (c % 300 == 299) do_reset();
      af = ($urandom_range(1) == 1);
      an = ($urandom_range(4) != 0) ? (m_head + mq.size()) % NN : int'($urandom_range(NN - 1));
      fq = ($urandom_range(1) == 1);
      if (mq.size() > 0 && $urandom_range(3) != 0)
        fn = mq[$urandom_range(mq.size() - 1)];
      else
        fn = int'($urandom_range(NN - 1));
      fr = ($urandom_range(3) != 0);
      drive_cycle(af, an, fq, fn, fr);
      chk_all("rand", m_head, model_wfe(), mq.size() < NN, mq.size(),
              mq.size() == 0, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
